// File: rtl/hit_resolver.sv
// rtl/hit_resolver.sv - two-stage facing-aware hitbox/hurtbox overlap and hit resolution for two players
// Stage 1 registers per-player boxes, stage 2 resolves connects into hit/blocked/damage pulses.
module hit_resolver #(
  parameter int unsigned        POS_W      = 10,
  parameter int unsigned        STATE_W    = 4,
  parameter int unsigned        FRAME_W    = 5,
  parameter int unsigned        DMG_W      = 6,
  parameter int unsigned        PLAYER_W   = 40,
  parameter logic [STATE_W-1:0] KICK_ST    = STATE_W'(3),
  parameter logic [STATE_W-1:0] GRAB_ST    = STATE_W'(4),
  parameter logic [STATE_W-1:0] BLOCK_ST   = STATE_W'(5),
  parameter int unsigned        KICK_ON    = 6,
  parameter int unsigned        KICK_OFF   = 8,
  parameter int unsigned        GRAB_ON    = 4,
  parameter int unsigned        GRAB_OFF   = 4,
  parameter int unsigned        KICK_RANGE = 30,
  parameter int unsigned        GRAB_RANGE = 12,
  parameter int unsigned        KICK_EXT   = 16,
  parameter int unsigned        GRAB_EXT   = 8,
  parameter int unsigned        KICK_DMG   = 10,
  parameter int unsigned        GRAB_DMG   = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STATE_W-1:0] p1_state,
  input  logic [FRAME_W-1:0] p1_frame,
  input  logic [POS_W-1:0]   p1_pos,
  input  logic               p1_face_left,
  input  logic [STATE_W-1:0] p2_state,
  input  logic [FRAME_W-1:0] p2_frame,
  input  logic [POS_W-1:0]   p2_pos,
  input  logic               p2_face_left,
  output logic               p1_hit,
  output logic               p1_blocked,
  output logic [DMG_W-1:0]   p1_damage,
  output logic               p2_hit,
  output logic               p2_blocked,
  output logic [DMG_W-1:0]   p2_damage
);

  localparam int unsigned BW = POS_W + 1;

  typedef enum logic [1:0] {K_NONE = 2'd0, K_KICK = 2'd1, K_GRAB = 2'd2} kind_e;
  typedef enum logic [1:0] {A_IDLE = 2'd0, A_ARMED = 2'd1, A_SPENT = 2'd2} atk_e;

  typedef struct packed {
    kind_e         kind;
    logic          act;
    logic [BW-1:0] hit_lo;
    logic [BW-1:0] hit_hi;
    logic [BW-1:0] hurt_lo;
    logic [BW-1:0] hurt_hi;
  } box_t;

  function automatic kind_e kind_of(input logic [STATE_W-1:0] st);
    kind_e k;
    k = K_NONE;
    if (st == KICK_ST)      k = K_KICK;
    else if (st == GRAB_ST) k = K_GRAB;
    return k;
  endfunction

  function automatic logic [BW-1:0] sat_sub(input logic [BW-1:0] a, input logic [BW-1:0] b);
    return (a >= b) ? (a - b) : '0;
  endfunction

  function automatic box_t build_box(input logic [STATE_W-1:0] st, input logic [FRAME_W-1:0] fr,
                                     input logic [POS_W-1:0] pos, input logic face_left);
    box_t          b;
    logic [BW-1:0] x;
    logic [BW-1:0] range;
    logic [BW-1:0] ext;
    b.kind = kind_of(st);
    x      = {1'b0, pos};
    range  = (b.kind == K_KICK) ? BW'(KICK_RANGE) : BW'(GRAB_RANGE);
    ext    = (b.kind == K_KICK) ? BW'(KICK_EXT) : ((b.kind == K_GRAB) ? BW'(GRAB_EXT) : '0);
    b.act  = ((b.kind == K_KICK) && (fr >= FRAME_W'(KICK_ON)) && (fr <= FRAME_W'(KICK_OFF))) ||
             ((b.kind == K_GRAB) && (fr >= FRAME_W'(GRAB_ON)) && (fr <= FRAME_W'(GRAB_OFF)));
    // Both boxes grow toward the facing side; left-side bounds clamp at screen edge 0.
    if (face_left) begin
      b.hit_lo  = sat_sub(x, range);
      b.hit_hi  = x;
      b.hurt_lo = sat_sub(x, ext);
      b.hurt_hi = x + BW'(PLAYER_W);
    end else begin
      b.hit_lo  = x + BW'(PLAYER_W);
      b.hit_hi  = x + BW'(PLAYER_W) + range;
      b.hurt_lo = x;
      b.hurt_hi = x + BW'(PLAYER_W) + ext;
    end
    return b;
  endfunction

  function automatic logic overlaps(input box_t atk, input box_t def);
    return (atk.hit_lo <= def.hurt_hi) && (def.hurt_lo <= atk.hit_hi);
  endfunction

  // A kind change (incoming vs pipe) starts a new instance; lock holds off arming after reset.
  function automatic atk_e atk_next(input atk_e cur, input kind_e k_in, input kind_e k_pipe,
                                    input logic lock, input logic fired);
    atk_e n;
    n = cur;
    if (k_in != k_pipe)                n = ((k_in != K_NONE) && !lock) ? A_ARMED : A_IDLE;
    else if (k_in == K_NONE)           n = A_IDLE;
    else if ((cur == A_ARMED) && fired) n = A_SPENT;
    return n;
  endfunction

  box_t               p1_box_d, p2_box_d, p1_box_q, p2_box_q;
  logic [STATE_W-1:0] p1_st_q, p2_st_q;
  atk_e               p1_atk_q, p1_atk_d, p2_atk_q, p2_atk_d;
  logic               p1_lock_q, p1_lock_d, p2_lock_q, p2_lock_d;
  logic               p1_conn, p2_conn, p1_kc, p1_gc, p2_kc, p2_gc;
  logic               p1_hit_d, p1_blk_d, p2_hit_d, p2_blk_d;
  logic [DMG_W-1:0]   p1_dmg_d, p2_dmg_d;
  logic               p1_hit_q, p1_blk_q, p2_hit_q, p2_blk_q;
  logic [DMG_W-1:0]   p1_dmg_q, p2_dmg_q;

  always_comb begin
    p1_box_d = build_box(p1_state, p1_frame, p1_pos, p1_face_left);
    p2_box_d = build_box(p2_state, p2_frame, p2_pos, p2_face_left);
  end

  always_comb begin
    p1_conn  = p1_box_q.act && overlaps(p1_box_q, p2_box_q) && (p1_atk_q == A_ARMED);
    p2_conn  = p2_box_q.act && overlaps(p2_box_q, p1_box_q) && (p2_atk_q == A_ARMED);
    p1_kc    = p1_conn && (p1_box_q.kind == K_KICK);
    p1_gc    = p1_conn && (p1_box_q.kind == K_GRAB);
    p2_kc    = p2_conn && (p2_box_q.kind == K_KICK);
    p2_gc    = p2_conn && (p2_box_q.kind == K_GRAB);
    // Kicks trade, grabs tech each other, a kick beats a grab, and only kicks can be blocked.
    p1_blk_d = p1_kc && (p2_st_q == BLOCK_ST);
    p2_blk_d = p2_kc && (p1_st_q == BLOCK_ST);
    p1_hit_d = (p1_kc && (p2_st_q != BLOCK_ST)) || (p1_gc && !p2_gc && !p2_kc);
    p2_hit_d = (p2_kc && (p1_st_q != BLOCK_ST)) || (p2_gc && !p1_gc && !p1_kc);
    p1_dmg_d = '0;
    p2_dmg_d = '0;
    if (p1_hit_d) p1_dmg_d = (p1_box_q.kind == K_KICK) ? DMG_W'(KICK_DMG) : DMG_W'(GRAB_DMG);
    if (p2_hit_d) p2_dmg_d = (p2_box_q.kind == K_KICK) ? DMG_W'(KICK_DMG) : DMG_W'(GRAB_DMG);
  end

  always_comb begin
    p1_atk_d  = atk_next(p1_atk_q, p1_box_d.kind, p1_box_q.kind, p1_lock_q, p1_hit_d || p1_blk_d);
    p2_atk_d  = atk_next(p2_atk_q, p2_box_d.kind, p2_box_q.kind, p2_lock_q, p2_hit_d || p2_blk_d);
    p1_lock_d = p1_lock_q && (p1_box_d.kind != K_NONE);
    p2_lock_d = p2_lock_q && (p2_box_d.kind != K_NONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_atk_q  <= A_IDLE;
      p2_atk_q  <= A_IDLE;
      p1_lock_q <= 1'b1;
      p2_lock_q <= 1'b1;
    end else begin
      p1_atk_q  <= p1_atk_d;
      p2_atk_q  <= p2_atk_d;
      p1_lock_q <= p1_lock_d;
      p2_lock_q <= p2_lock_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_box_q <= '0;
      p2_box_q <= '0;
      p1_st_q  <= '0;
      p2_st_q  <= '0;
      p1_hit_q <= 1'b0;
      p1_blk_q <= 1'b0;
      p1_dmg_q <= '0;
      p2_hit_q <= 1'b0;
      p2_blk_q <= 1'b0;
      p2_dmg_q <= '0;
    end else begin
      p1_box_q <= p1_box_d;
      p2_box_q <= p2_box_d;
      p1_st_q  <= p1_state;
      p2_st_q  <= p2_state;
      p1_hit_q <= p1_hit_d;
      p1_blk_q <= p1_blk_d;
      p1_dmg_q <= p1_dmg_d;
      p2_hit_q <= p2_hit_d;
      p2_blk_q <= p2_blk_d;
      p2_dmg_q <= p2_dmg_d;
    end
  end

  assign p1_hit     = p1_hit_q;
  assign p1_blocked = p1_blk_q;
  assign p1_damage  = p1_dmg_q;
  assign p2_hit     = p2_hit_q;
  assign p2_blocked = p2_blk_q;
  assign p2_damage  = p2_dmg_q;

endmodule

// File: tb/tb_hit_resolver.sv
// tb/tb_hit_resolver.sv - directed checks of hit_resolver boxes, resolution, attack FSM and reset
module tb_hit_resolver;

  localparam logic [3:0] IDL = 4'd0, KCK = 4'd3, GRB = 4'd4, BLK = 4'd5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] p1_state = '0, p2_state = '0;
  logic [4:0] p1_frame = '0, p2_frame = '0;
  logic [9:0] p1_pos = '0, p2_pos = '0;
  logic       p1_face_left = 1'b0, p2_face_left = 1'b0;
  logic       p1_hit, p1_blocked, p2_hit, p2_blocked;
  logic [5:0] p1_damage, p2_damage;
  int         errors = 0;
  int         checks = 0;

  hit_resolver dut (
    .clk(clk), .reset(reset),
    .p1_state(p1_state), .p1_frame(p1_frame), .p1_pos(p1_pos), .p1_face_left(p1_face_left),
    .p2_state(p2_state), .p2_frame(p2_frame), .p2_pos(p2_pos), .p2_face_left(p2_face_left),
    .p1_hit(p1_hit), .p1_blocked(p1_blocked), .p1_damage(p1_damage),
    .p2_hit(p2_hit), .p2_blocked(p2_blocked), .p2_damage(p2_damage)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ex(input logic h1, input logic b1, input logic [5:0] d1,
                                     input logic h2, input logic b2, input logic [5:0] d2);
    return {h1, b1, d1, h2, b2, d2};
  endfunction

  localparam logic [15:0] NONE = 16'h0000;

  task automatic check(input string tag, input logic [15:0] exp);
    logic [15:0] obs;
    obs = {p1_hit, p1_blocked, p1_damage, p2_hit, p2_blocked, p2_damage};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed {h1,b1,d1,h2,b2,d2}=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after the next edge.
  task automatic step(input string tag,
                      input logic [3:0] s1, input logic [4:0] f1, input logic [9:0] x1, input logic l1,
                      input logic [3:0] s2, input logic [4:0] f2, input logic [9:0] x2, input logic l2,
                      input logic [15:0] exp);
    p1_state = s1; p1_frame = f1; p1_pos = x1; p1_face_left = l1;
    p2_state = s2; p2_frame = f2; p2_pos = x2; p2_face_left = l2;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    logic [15:0] p1k, p2g, p1b, both_k;
    p1k    = ex(1'b1, 1'b0, 6'd10, 1'b0, 1'b0, 6'd0);
    p2g    = ex(1'b0, 1'b0, 6'd0,  1'b1, 1'b0, 6'd15);
    p1b    = ex(1'b0, 1'b1, 6'd0,  1'b0, 1'b0, 6'd0);
    both_k = ex(1'b1, 1'b0, 6'd10, 1'b1, 1'b0, 6'd10);

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", NONE);
    reset = 1'b1;
    step("idle_a", IDL, 0, 100, 0, IDL, 0, 170, 1, NONE);
    step("idle_b", IDL, 0, 100, 0, IDL, 0, 170, 1, NONE);

    // p1 kick right from 100 reaches 170 exactly; p2 body starts at 170
    step("t1_f5",   KCK, 5, 100, 0, IDL, 0, 170, 1, NONE);
    step("t1_f6",   KCK, 6, 100, 0, IDL, 0, 170, 1, NONE);
    step("t1_f7",   KCK, 7, 100, 0, IDL, 0, 170, 1, p1k);
    step("t1_f8",   KCK, 8, 100, 0, IDL, 0, 170, 1, NONE);
    step("t1_f9",   KCK, 9, 100, 0, IDL, 0, 170, 1, NONE);
    step("t1_idle", IDL, 0, 100, 0, IDL, 0, 170, 1, NONE);

    step("t1b_f5",   KCK, 5, 100, 0, IDL, 0, 171, 1, NONE);
    step("t1b_f6",   KCK, 6, 100, 0, IDL, 0, 171, 1, NONE);
    step("t1b_f7",   KCK, 7, 100, 0, IDL, 0, 171, 1, NONE);
    step("t1b_f8",   KCK, 8, 100, 0, IDL, 0, 171, 1, NONE);
    step("t1b_idle", IDL, 0, 100, 0, IDL, 0, 171, 1, NONE);

    step("t2_f5",   KCK, 5, 100, 0, BLK, 0, 170, 1, NONE);
    step("t2_f6",   KCK, 6, 100, 0, BLK, 0, 170, 1, NONE);
    step("t2_f7",   KCK, 7, 100, 0, BLK, 0, 170, 1, p1b);
    step("t2_f8",   KCK, 8, 100, 0, BLK, 0, 170, 1, NONE);
    step("t2_idle", IDL, 0, 100, 0, IDL, 0, 170, 1, NONE);

    // p2 grab left from 150, gap 10 to p1 body edge at 140, p1 blocking
    step("t2g_f3",   BLK, 0, 100, 0, GRB, 3, 150, 1, NONE);
    step("t2g_f4",   BLK, 0, 100, 0, GRB, 4, 150, 1, NONE);
    step("t2g_f5",   BLK, 0, 100, 0, GRB, 5, 150, 1, p2g);
    step("t2g_idle", IDL, 0, 100, 0, IDL, 0, 150, 1, NONE);

    step("t3_f5",   KCK, 5, 100, 0, KCK, 5, 170, 1, NONE);
    step("t3_f6",   KCK, 6, 100, 0, KCK, 6, 170, 1, NONE);
    step("t3_f7",   KCK, 7, 100, 0, KCK, 7, 170, 1, both_k);
    step("t3_f8",   KCK, 8, 100, 0, KCK, 8, 170, 1, NONE);
    step("t3_idle", IDL, 0, 100, 0, IDL, 0, 170, 1, NONE);

    step("t3g_f3",   GRB, 3, 100, 0, GRB, 3, 140, 1, NONE);
    step("t3g_f4",   GRB, 4, 100, 0, GRB, 4, 140, 1, NONE);
    step("t3g_f5",   GRB, 5, 100, 0, GRB, 5, 140, 1, NONE);
    step("t3g_idle", IDL, 0, 100, 0, IDL, 0, 140, 1, NONE);

    step("t4_a",    KCK, 5, 100, 0, GRB, 3, 150, 1, NONE);
    step("t4_b",    KCK, 6, 100, 0, GRB, 4, 150, 1, NONE);
    step("t4_c",    KCK, 7, 100, 0, GRB, 5, 150, 1, p1k);
    step("t4_d",    KCK, 8, 100, 0, GRB, 6, 150, 1, NONE);
    step("t4_idle", IDL, 0, 100, 0, IDL, 0, 150, 1, NONE);

    step("t4s_far_f5", KCK, 5, 5, 1, IDL, 0, 900, 0, NONE);
    step("t4s_far_f6", KCK, 6, 5, 1, IDL, 0, 900, 0, NONE);
    step("t4s_far_f7", KCK, 7, 5, 1, IDL, 0, 900, 0, NONE);
    step("t4s_far_id", IDL, 0, 5, 1, IDL, 0, 900, 0, NONE);
    step("t4s_sat_f5", KCK, 5, 5, 1, IDL, 0, 0, 0, NONE);
    step("t4s_sat_f6", KCK, 6, 5, 1, IDL, 0, 0, 0, NONE);
    step("t4s_sat_f7", KCK, 7, 5, 1, IDL, 0, 0, 0, p1k);
    step("t4s_sat_id", IDL, 0, 5, 1, IDL, 0, 0, 0, NONE);

    step("t5_f5", KCK, 5, 100, 0, IDL, 0, 170, 1, NONE);
    step("t5_f6", KCK, 6, 100, 0, IDL, 0, 170, 1, NONE);
    step("t5_f7", KCK, 7, 100, 0, IDL, 0, 170, 1, p1k);
    reset = 1'b0;
    #1;
    check("t5_async_clear", NONE);
    @(posedge clk);
    #1;
    check("t5_held", NONE);
    reset = 1'b1;
    step("t5_rel_f8", KCK, 8, 100, 0, IDL, 0, 170, 1, NONE);
    step("t5_rel_f9", KCK, 9, 100, 0, IDL, 0, 170, 1, NONE);
    step("t5_exit",   IDL, 0, 100, 0, IDL, 0, 170, 1, NONE);
    step("t5_re_f5",  KCK, 5, 100, 0, IDL, 0, 170, 1, NONE);
    step("t5_re_f6",  KCK, 6, 100, 0, IDL, 0, 170, 1, NONE);
    step("t5_re_f7",  KCK, 7, 100, 0, IDL, 0, 170, 1, p1k);
    step("t5_re_id",  IDL, 0, 100, 0, IDL, 0, 170, 1, NONE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
